// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the 5-stage RV32 core.
//               Each cycle it decides whether every pipeline register
//               advances, holds, or loads a bubble/flush:
//                 - load-use hazard detection in ID (one-cycle bubble)
//                 - branch-taken flush when a BEQ resolves in MEM
//                 - whole-pipe hold while data memory is waiting
//                 - watchdog that latches a sticky error if data memory
//                   never answers (state ERR, left only through reset)
//               Hazard and flush outputs are combinational from the current
//               state and inputs, so they take effect in the same cycle.
//
// Optional    : HAZARD_PERF_CNT_EN (macro) adds saturating counters
//               stall_cycles_o and flush_events_o.
//
// Parameters  : MEM_TIMEOUT  consecutive memory-wait cycles tolerated (>=2)
//               CNT_W        performance counter width (macro build only)
//
// Ports       : clk_i               core clock, rising edge
//               rst_n_i             synchronous active-low reset
//               id_rs1_i, id_rs2_i  source registers of the IF/ID instruction
//               id_uses_rs2_i       ID instruction reads rs2
//               ex_mem_read_i       ID/EX instruction is a load
//               ex_rd_i             ID/EX destination register
//               mem_branch_taken_i  EX/MEM branch resolved taken
//               mem_access_i        EX/MEM instruction accesses data memory
//               dmem_ready_i        data memory completes access this cycle
//               pc_write_o          PC load enable
//               ifid_write_o        IF/ID load enable
//               ifid_flush_o        IF/ID clear to NOP
//               idex_bubble_o       zero control fields loaded into ID/EX
//               idex_hold_o         ID/EX keeps contents
//               exmem_flush_o       zero control fields loaded into EX/MEM
//               exmem_hold_o        EX/MEM keeps contents
//               memwb_bubble_o      zero control fields loaded into MEM/WB
//               dmem_timeout_o      sticky data-memory timeout error
//               stall_cycles_o      cycles with pc_write_o=0 (macro only)
//               flush_events_o      branch flush count (macro only)
//
// Revision    : 1.0  initial release
// ============================================================================

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             mem_branch_taken_i,
    input  logic             mem_access_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             idex_hold_o,
    output logic             exmem_flush_o,
    output logic             exmem_hold_o,
    output logic             memwb_bubble_o,
    output logic             dmem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    // Wait-counter value seen on the last tolerated wait cycle.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,        state_d;
    logic [WCNT_W-1:0] wcnt_q,         wcnt_d;
    logic              dmem_timeout_q, dmem_timeout_d;

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    logic w_mem_wait;
    logic w_load_use;

    // A pending access with memory not ready. In MEM_WAIT, either a ready
    // response or mem_access dropping ends the wait; both look like release.
    assign w_mem_wait = mem_access_i & ~dmem_ready_i;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_mem_read_i
                      & (ex_rd_i != 5'd0)
                      & ((ex_rd_i == id_rs1_i)
                         | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_RUN;
            wcnt_q         <= '0;
            dmem_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            dmem_timeout_q <= dmem_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        dmem_timeout_d = dmem_timeout_q;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_wait) begin
                    // wcnt counts wait cycles already spent, so the cycle
                    // holding WCNT_LAST is the MEM_TIMEOUT-th wait.
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d        = ST_ERR;
                        dmem_timeout_d = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end
            end

            ST_ERR: begin
                // Terminal until reset.
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        idex_hold_o    = 1'b0;
        exmem_flush_o  = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;

        if (!rst_n_i) begin
            // Keep the pipe empty while reset is held.
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            exmem_flush_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if ((state_q == ST_ERR) || w_mem_wait) begin
            // Freeze everything up to EX/MEM; MEM/WB receives bubbles so a
            // waiting access is not written back more than once.
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_hold_o    = 1'b1;
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (mem_branch_taken_i) begin
            // Squash the three younger instructions; PC takes the target.
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            exmem_flush_o  = 1'b1;
        end else if (w_load_use) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_bubble_o  = 1'b1;
        end
    end

    assign dmem_timeout_o = dmem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic             w_flush_evt;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_events_q;

    assign w_flush_evt = rst_n_i & (state_q != ST_ERR) & ~w_mem_wait
                       & mem_branch_taken_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (!pc_write_o && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (w_flush_evt && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + 1'b1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;
`else
    // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A constant vector table
//               walks the directed scenarios, hand sequences cover the
//               counter corner cases, and a randomized phase compares against
//               a rule-level reference model.
// Revision    : 1.0  initial release
// ============================================================================

module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 16;

    // Output patterns {pc_write, ifid_write, ifid_flush, idex_bubble,
    //                  idex_hold, exmem_flush, exmem_hold, memwb_bubble,
    //                  dmem_timeout}
    localparam logic [8:0] P_NORM  = 9'b110000000;
    localparam logic [8:0] P_RST0  = 9'b001101010;
    localparam logic [8:0] P_RST1  = 9'b001101011;
    localparam logic [8:0] P_WAIT  = 9'b000010110;
    localparam logic [8:0] P_ERR   = 9'b000010111;
    localparam logic [8:0] P_FLUSH = 9'b111101000;
    localparam logic [8:0] P_LU    = 9'b000100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, ex_rd;
    logic       uses_rs2, ex_mr, br, acc, rdy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold;
    logic       exmem_flush, exmem_hold, memwb_bubble, dmem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .id_rs1_i           (rs1),
        .id_rs2_i           (rs2),
        .id_uses_rs2_i      (uses_rs2),
        .ex_mem_read_i      (ex_mr),
        .ex_rd_i            (ex_rd),
        .mem_branch_taken_i (br),
        .mem_access_i       (acc),
        .dmem_ready_i       (rdy),
        .pc_write_o         (pc_write),
        .ifid_write_o       (ifid_write),
        .ifid_flush_o       (ifid_flush),
        .idex_bubble_o      (idex_bubble),
        .idex_hold_o        (idex_hold),
        .exmem_flush_o      (exmem_flush),
        .exmem_hold_o       (exmem_hold),
        .memwb_bubble_o     (memwb_bubble),
        .dmem_timeout_o     (dmem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o     (stall_cycles),
        .flush_events_o     (flush_events)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[23];
    int   checks = 0;
    int   errors = 0;

    // Reference model: consecutive wait count, sticky error, counters.
    int  m_wait  = 0;
    bit  m_err   = 1'b0;
    int  m_stall = 0;
    int  m_flush = 0;
    bit  chk_cnt = 1'b0;

    function automatic vec_t mkv(input logic r, input logic [4:0] a,
                                 input logic [4:0] b, input logic u,
                                 input logic m, input logic [4:0] d,
                                 input logic bt, input logic ac,
                                 input logic rd_y, input logic [8:0] e);
        vec_t v;
        v.rst_n = r; v.rs1 = a; v.rs2 = b; v.uses = u; v.mr = m; v.rd = d;
        v.br = bt; v.acc = ac; v.rdy = rd_y; v.exp = e;
        return v;
    endfunction

    function automatic logic [8:0] model_out();
        bit lu;
        lu = ex_mr && (ex_rd != 0) &&
             ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
        if (!rst_n)              return {8'b00110101, m_err};
        else if (m_err)          return P_ERR;
        else if (acc && !rdy)    return P_WAIT;
        else if (br)             return P_FLUSH;
        else if (lu)             return P_LU;
        else                     return P_NORM;
    endfunction

    task automatic model_step();
        logic [8:0] e;
        e = model_out();
        if (!rst_n) begin
            m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[8] && m_stall < 32'hFFFF) m_stall++;
            if (e == P_FLUSH && m_flush < 32'hFFFF) m_flush++;
            if (!m_err) begin
                if (acc && !rdy) begin
                    m_wait++;
                    if (m_wait >= MT) m_err = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [8:0] pack();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
                exmem_flush, exmem_hold, memwb_bubble, dmem_timeout};
    endfunction

    // One cycle: drive at negedge, check 1ns later, advance model at posedge.
    // use_tbl selects the constant expectation from v instead of the model.
    task automatic step(input vec_t v, input bit use_tbl, input string nm);
        @(negedge clk);
        rst_n = v.rst_n; rs1 = v.rs1; rs2 = v.rs2; uses_rs2 = v.uses;
        ex_mr = v.mr; ex_rd = v.rd; br = v.br; acc = v.acc; rdy = v.rdy;
        #1;
        if (use_tbl) cmp(nm, 32'(pack()), 32'(v.exp));
        else         cmp(nm, 32'(pack()), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
        if (chk_cnt) begin
            cmp({nm, "_stall_cnt"}, 32'(stall_cycles), 32'(m_stall));
            cmp({nm, "_flush_cnt"}, 32'(flush_events), 32'(m_flush));
        end
`endif
        @(posedge clk);
        model_step();
    endtask

    initial begin
        vec_t v;

        //             rst rs1   rs2   u  mr rd    br ac rdy exp
        tbl[0]  = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_RST0);
        tbl[1]  = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_NORM);
        tbl[2]  = mkv(1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, P_LU);
        tbl[3]  = mkv(1, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, P_NORM);
        tbl[4]  = mkv(1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, P_NORM);
        tbl[5]  = mkv(1, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, P_NORM);
        tbl[6]  = mkv(1, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, P_LU);
        tbl[7]  = mkv(1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 0, P_FLUSH);
        tbl[8]  = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, P_WAIT);
        tbl[9]  = mkv(1, 5'd3, 5'd0, 0, 1, 5'd3, 0, 1, 0, P_WAIT);
        tbl[10] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, P_WAIT);
        tbl[11] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, P_FLUSH);
        tbl[12] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_NORM);
        tbl[13] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, P_WAIT);
        tbl[14] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_NORM);
        tbl[15] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, P_WAIT);
        tbl[16] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, P_WAIT);
        tbl[17] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, P_WAIT);
        tbl[18] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, P_WAIT);
        tbl[19] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, P_ERR);
        tbl[20] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_ERR);
        tbl[21] = mkv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_RST1);
        tbl[22] = mkv(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, P_NORM);

        // Bring registers out of X before any comparison.
        rst_n = 1'b0; rs1 = '0; rs2 = '0; ex_rd = '0;
        uses_rs2 = 1'b0; ex_mr = 1'b0; br = 1'b0; acc = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Counter sequence from a fresh reset: 3 waits, release, flush.
        chk_cnt = 1'b1;
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RST0), 1'b1, "seq_rst");
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, P_NORM), 1'b1, "seq_idle");
        for (int i = 0; i < 3; i++)
            step(mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, P_WAIT), 1'b1, "seq_wait");
        step(mkv(1, 0, 0, 0, 0, 0, 0, 1, 1, P_NORM), 1'b1, "seq_release");
        step(mkv(1, 5'd9, 0, 0, 1, 5'd9, 1, 0, 0, P_FLUSH), 1'b1, "seq_flush");
        step(mkv(1, 5'd9, 0, 0, 0, 5'd9, 0, 0, 0, P_NORM), 1'b1, "seq_after");
`ifdef HAZARD_PERF_CNT_EN
        cmp("seq_stall_eq3", 32'(stall_cycles), 32'd3);
        cmp("seq_flush_eq1", 32'(flush_events), 32'd1);
`endif

        // Timeout, ERR persistence, reset out of ERR.
        for (int i = 0; i < MT; i++)
            step(mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, P_WAIT), 1'b1, "to_wait");
        step(mkv(1, 0, 0, 0, 0, 0, 0, 1, 1, P_ERR), 1'b1, "to_err_rdy");
        step(mkv(1, 0, 0, 0, 0, 0, 1, 0, 0, P_ERR), 1'b1, "to_err_br");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RST1), 1'b1, "to_rst");
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, P_NORM), 1'b1, "to_idle");
`ifdef HAZARD_PERF_CNT_EN
        cmp("to_flush_cleared", 32'(flush_events), 32'd0);
`endif

        // Randomized phase against the reference model.
        for (int n = 0; n < 3000; n++) begin
            v.rst_n = ($urandom_range(0, 39) != 0);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.uses  = 1'($urandom_range(0, 1));
            v.mr    = 1'($urandom_range(0, 1));
            v.rd    = 5'($urandom_range(0, 3));
            v.br    = ($urandom_range(0, 4) == 0);
            v.acc   = ($urandom_range(0, 9) < 6);
            v.rdy   = ($urandom_range(0, 9) < 4);
            v.exp   = '0;
            step(v, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core: it decides every cycle whether each pipeline register advances, holds, or is bubbled/flushed. It detects load-use hazards in ID, applies a branch-taken flush when a BEQ resolves in MEM, and stalls the whole pipe on a data-memory wait handshake. A timeout FSM latches a sticky error if data memory never responds. It sits beside the ID-stage control unit and drives the enables and clears of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MEM_TIMEOUT, 16, max consecutive data-memory wait cycles before error; legal ≥2
- CNT_W, 32, width of performance counters (only with HAZARD_PERF_CNT_EN)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- id_rs1, id_rs2  in  5 each  source register fields of instruction in IF/ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, BEQ)
- ex_mem_read  in  1  M_mem_read of instruction in ID/EX
- ex_rd  in  5  destination register of instruction in ID/EX
- mem_branch_taken  in  1  EX/MEM M_branch AND ALU zero
- mem_access  in  1  EX/MEM mem_read OR mem_write
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_bubble  out  1  zero all control fields loaded into ID/EX
- idex_hold  out  1  ID/EX keeps contents
- exmem_flush  out  1  zero control fields loaded into EX/MEM
- exmem_hold  out  1  EX/MEM keeps contents
- memwb_bubble  out  1  zero control fields loaded into MEM/WB
- dmem_timeout  out  1  sticky error, set on timeout, cleared only by reset
- stall_cycles  out  CNT_W  cycles with pc_write=0 (macro only)
- flush_events  out  CNT_W  count of branch flushes (macro only)

## Operation
- States: RUN, MEM_WAIT, ERR. Wait counter wcnt, width $clog2(MEM_TIMEOUT+1).
- Condition priority per cycle, highest first: ERR state, memory wait, branch flush, load-use.
- Memory wait (RUN or MEM_WAIT, mem_access=1, dmem_ready=0): pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1; branch and load-use ignored. Next state MEM_WAIT, wcnt+1.
- Release: mem_access=1, dmem_ready=1 in MEM_WAIT → normal RUN outputs that cycle (branch/load-use evaluated), next state RUN, wcnt=0.
- Timeout: a wait cycle with wcnt==MEM_TIMEOUT-1 → next state ERR. ERR: wait outputs asserted every cycle regardless of inputs, dmem_timeout=1; exit only via reset.
- Branch flush (RUN, no wait): ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1, ifid_write=1; load-use suppressed.
- Load-use (RUN, no wait, no flush): ex_mem_read=1, ex_rd≠0, and (ex_rd==id_rs1 or (id_uses_rs2 and ex_rd==id_rs2)) → pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
- Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- x0 never causes a stall.

## Timing
- Hazard/flush outputs combinational from state and current inputs; zero-cycle latency. State, wcnt, dmem_timeout, counters registered.
- Load-use costs exactly 1 bubble; next cycle the load is in EX/MEM and the condition clears naturally.
- While rst_n=0 (sampled at edge, registers cleared): state=RUN, wcnt=0, dmem_timeout=0, counters 0; outputs forced pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, memwb_bubble=1, holds=0.
- Reset mid-MEM_WAIT or in ERR: returns to RUN on the next edge, no residual hold.
- mem_access dropping while in MEM_WAIT (illegal) → treated as release.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles increments each non-reset cycle with pc_write=0 (incl. ERR); flush_events increments each branch-flush cycle; both saturate at all-ones.
- Not defined: both counter ports and their logic absent; all other behaviour identical.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5 → one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_mem_read=0) all normal.
- ex_mem_read=1, ex_rd=0, id_rs1=0 → no stall; ex_rd=7, id_rs2=7, id_uses_rs2=0 → no stall.
- mem_branch_taken=1 with simultaneous load-use → ifid_flush=idex_bubble=exmem_flush=1, pc_write=1; flush_events +1.
- mem_access=1, dmem_ready low 3 cycles then high → 3 cycles full hold with memwb_bubble=1, release on 4th, stall_cycles +3.
- MEM_TIMEOUT=4, dmem_ready never high → after 4 wait cycles state ERR, dmem_timeout=1, holds persist; raising dmem_ready changes nothing.
- rst_n=0 during ERR → next cycle dmem_timeout=0, counters 0, reset output pattern; after rst_n=1 with idle inputs pc_write=1, ifid_write=1.
